// File: rtl/set_cache_tag_controller.sv
// Tag/valid/dirty store and miss sequencer for a set-associative cache.
// Hits return the slot directly; misses go through replacement, optional writeback and fetch.
module set_cache_tag_controller #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    parameter int BW_ADDR              = 24,
    localparam int BW_CACHE    = $clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_WAY      = $clog2(CACHE_SET_SIZE),
    localparam bit FULLY_ASSOC = (CACHE_SET_SIZE == CACHE_BLOCK_CAPACITY),
    localparam int BW_GRP      = FULLY_ASSOC ? 1 : BW_CACHE - BW_WAY,
    localparam int BW_TAG      = FULLY_ASSOC ? BW_ADDR : BW_ADDR - BW_GRP
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                req_i,
    input  logic [BW_ADDR-1:0]  req_addr_i,
    input  logic                req_wren_i,
    output logic                ready_o,
    output logic                done_o,
    output logic                hit_o,
    output logic [BW_CACHE-1:0] cache_addr_o,
    output logic                repl_miss_o,
    output logic [BW_GRP-1:0]   repl_group_o,
    input  logic                repl_done_i,
    input  logic [BW_CACHE-1:0] repl_addr_i,
    output logic                mem_req_o,
    output logic                mem_wb_o,
    output logic [BW_ADDR-1:0]  mem_addr_o,
    output logic [BW_CACHE-1:0] mem_cache_addr_o,
    input  logic                mem_ack_i
);

    localparam int GRP_BITS = FULLY_ASSOC ? 0 : BW_GRP;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, REPL, REPL_WAIT, WB, WB_GAP, FETCH, UPDATE
    } state_t;

    state_t                    state_q, state_d;
    logic [BW_ADDR-1:0]        reqAddr_q, reqAddr_d;
    logic                      reqWren_q, reqWren_d;
    logic [BW_CACHE-1:0]       victim_q, victim_d;
    logic                      done_q, done_d;
    logic                      hit_q, hit_d;
    logic                      replMiss_q, replMiss_d;
    logic [BW_CACHE-1:0]       cacheAddr_q, cacheAddr_d;

    logic [BW_TAG-1:0]         tagMem_q [CACHE_BLOCK_CAPACITY];
    logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
    logic [CACHE_BLOCK_CAPACITY-1:0] dirty_q;

    logic [BW_TAG-1:0]         reqTag;
    logic [BW_GRP-1:0]         reqGroup;
    logic                      lookupHit;
    logic [BW_CACHE-1:0]       hitSlot;
    logic                      victimDirty;
    logic [BW_ADDR-1:0]        wbAddr;

    // Slot index is {way, group}; with a single set the group field vanishes.
    function automatic logic [BW_CACHE-1:0] slotOf(input int way, input logic [BW_GRP-1:0] grp);
        return (BW_CACHE'(way) << GRP_BITS) | BW_CACHE'(grp);
    endfunction

    assign reqTag      = reqAddr_q[BW_ADDR-1 -: BW_TAG];
    assign reqGroup    = FULLY_ASSOC ? '0 : reqAddr_q[BW_GRP-1:0];
    assign victimDirty = valid_q[repl_addr_i] & dirty_q[repl_addr_i];
    assign wbAddr      = (BW_ADDR'(tagMem_q[victim_q]) << GRP_BITS) | BW_ADDR'(reqGroup);

    // Descending scan so that the lowest matching way wins.
    always_comb begin
        lookupHit = 1'b0;
        hitSlot   = '0;
        for (int w = CACHE_SET_SIZE - 1; w >= 0; w--) begin
            if (valid_q[slotOf(w, reqGroup)] && (tagMem_q[slotOf(w, reqGroup)] == reqTag)) begin
                lookupHit = 1'b1;
                hitSlot   = slotOf(w, reqGroup);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        reqAddr_d   = reqAddr_q;
        reqWren_d   = reqWren_q;
        victim_d    = victim_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        replMiss_d  = 1'b0;
        cacheAddr_d = cacheAddr_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    reqAddr_d = req_addr_i;
                    reqWren_d = req_wren_i;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookupHit) begin
                    done_d      = 1'b1;
                    hit_d       = 1'b1;
                    cacheAddr_d = hitSlot;
                    state_d     = IDLE;
                end else begin
                    replMiss_d = 1'b1;
                    state_d    = REPL;
                end
            end
            REPL:      state_d = REPL_WAIT;
            REPL_WAIT: begin
                if (repl_done_i) begin
                    victim_d = repl_addr_i;
                    state_d  = victimDirty ? WB : FETCH;
                end
            end
            WB:        if (mem_ack_i) state_d = WB_GAP;
            WB_GAP:    state_d = FETCH;
            FETCH:     if (mem_ack_i) state_d = UPDATE;
            UPDATE: begin
                done_d      = 1'b1;
                cacheAddr_d = victim_q;
                state_d     = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            reqAddr_q   <= '0;
            reqWren_q   <= 1'b0;
            victim_q    <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            replMiss_q  <= 1'b0;
            cacheAddr_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            reqWren_q   <= reqWren_d;
            victim_q    <= victim_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            replMiss_q  <= replMiss_d;
            cacheAddr_q <= cacheAddr_d;
            if (state_q == UPDATE) begin
                valid_q[victim_q] <= 1'b1;
                dirty_q[victim_q] <= reqWren_q;
            end else if ((state_q == LOOKUP) && lookupHit && reqWren_q) begin
                dirty_q[hitSlot] <= 1'b1;
            end
        end
    end

    // Tags need no reset: a slot's tag is only consulted once its valid bit is set.
    always_ff @(posedge clock_i) begin
        if (state_q == UPDATE) begin
            tagMem_q[victim_q] <= reqTag;
        end
    end

    assign ready_o          = (state_q == IDLE);
    assign done_o           = done_q;
    assign hit_o            = hit_q;
    assign cache_addr_o     = cacheAddr_q;
    assign repl_miss_o      = replMiss_q;
    assign repl_group_o     = (state_q == REPL) ? reqGroup : '0;
    assign mem_req_o        = (state_q == WB) || (state_q == FETCH);
    assign mem_wb_o         = (state_q == WB);
    assign mem_addr_o       = (state_q == WB) ? wbAddr : (state_q == FETCH) ? reqAddr_q : '0;
    assign mem_cache_addr_o = mem_req_o ? victim_q : '0;

endmodule
